// File: rtl/mux_segment_counter_if.sv
// Bundle of the counter's control inputs and the display/value outputs.
// The design drives the slave side; a board wrapper or bench drives the master side.
interface mux_segment_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   value;
  logic                  tick;
  logic                  carry;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     dig;

  modport master (
    output en, up, clr, load, load_val,
    input  value, tick, carry, seg, dig
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output value, tick, carry, seg, dig
  );
endinterface

// File: rtl/mux_segment_counter.sv
// Multi-digit hex/BCD up/down counter with prescaled tick, load/clear, and a
// time-multiplexed 7-segment display driver with one-hot digit enables.
module mux_segment_counter #(
  parameter int DIGITS         = 4,
  parameter int BASE           = 16,
  parameter int TICK_DIV       = 3200000,
  parameter int SCAN_DIV       = 16000,
  parameter int BLANK_LZ       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  mux_segment_counter_if.slave bus
);

  localparam int VW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [3:0]    DMAX       = 4'(BASE - 1);

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
    endcase
  endfunction

  // In BCD mode a loaded nibble above 9 saturates to 9.
  function automatic logic [VW-1:0] clamp_load(input logic [VW-1:0] v);
    clamp_load = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (BASE == 10 && v[4*k +: 4] > 4'd9) clamp_load[4*k +: 4] = 4'd9;
    end
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [VW-1:0] value_q, value_d;
  logic          tick_q, tick_d;
  logic          carry_q, carry_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;

  logic [VW-1:0] step_val;
  logic          chain;
  logic [3:0]    cur;
  logic          upper_nz;
  logic          blank;

  // Ripple +/-1 across all digits; chain left set means every digit wrapped.
  always_comb begin
    step_val = value_q;
    chain    = 1'b1;
    cur      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      cur = value_q[4*k +: 4];
      if (chain) begin
        if (bus.up) begin
          if (cur == DMAX) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = cur + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (cur == 4'd0) begin
            step_val[4*k +: 4] = DMAX;
          end else begin
            step_val[4*k +: 4] = cur - 4'd1;
            chain = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    value_d = value_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (bus.clr) begin
      value_d = '0;
      presc_d = '0;
    end else if (bus.load) begin
      value_d = clamp_load(bus.load_val);
      presc_d = '0;
    end else if (bus.en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        value_d = step_val;
        tick_d  = 1'b1;
        carry_d = chain;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // SEG/DIG are built from next-state index and value so the registered
  // outputs always show the digit of the value currently held in value_q.
  always_comb begin
    upper_nz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_d) && value_d[4*k +: 4] != 4'd0) upper_nz = 1'b1;
    end
    blank  = (BLANK_LZ != 0) && (idx_d != '0) && !upper_nz;
    seg_d  = blank ? 7'h00 : glyph(value_d[4*idx_d +: 4]);
    dig_d  = '0;
    dig_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      value_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h3F;
      dig_q   <= DIGITS'(1);
    end else begin
      presc_q <= presc_d;
      value_q <= value_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.value = value_q;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;
  assign bus.seg   = seg_q ^ {7{(SEG_ACTIVE_LOW != 0)}};
  assign bus.dig   = dig_q ^ {DIGITS{(DIG_ACTIVE_LOW != 0)}};

endmodule

// File: doc/mux_segment_counter.md
Name: mux_segment_counter

Overview:
- Parametrised multi-digit successor to the single-digit 7-segment counter demo.
- A prescaler generates a count tick. A DIGITS-wide hex or BCD counter counts up or down on each tick, and supports load and clear.
- The value is time-multiplexed onto one shared 7-segment bus with one-hot digit enables.
- Sits between board pins and any logic needing a visible counter or numeric readout.

Parameters:
- DIGITS, 4, number of digits; legal range 1..8.
- BASE, 16, per-digit radix; legal values 16 (hex) or 10 (BCD).
- TICK_DIV, 3200000, CLK cycles per count tick while EN=1; must be >=2.
- SCAN_DIV, 16000, CLK cycles each digit is displayed; must be >=2.
- BLANK_LZ, 0, 1 = blank leading zero digits; digit 0 is never blanked.
- SEG_ACTIVE_LOW, 0, 1 = SEG bits are inverted at the output.
- DIG_ACTIVE_LOW, 1, 1 = DIG bits are inverted at the output.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- EN  in  1  count enable; prescaler advances only while high.
- UP  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- CLR  in  1  synchronous clear.
- LOAD  in  1  synchronous load.
- LOAD_VAL  in  4*DIGITS  value to load; 4 bits per digit, digit 0 in the LSBs.
- VALUE  out  4*DIGITS  current counter value.
- TICK  out  1  one-cycle pulse on every count step.
- CARRY  out  1  one-cycle pulse on full-range wrap; coincident with TICK.
- SEG  out  7  segment drive; bit0=a ... bit6=g.
- DIG  out  DIGITS  one-hot digit enable.

Behaviour:
- Reset (RESET_N=0, async):
  - prescaler = 0, VALUE = 0, scan counter = 0, digit index = 0.
  - TICK = 0, CARRY = 0.
  - DIG selects digit 0, SEG = glyph '0' (7'h3F before polarity).
  - All outputs reach these values without needing a clock edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 while EN=1 and holds while EN=0.
  - At terminal count with EN=1 it wraps to 0 and raises an internal tick.
  - Tick period is exactly TICK_DIV cycles.
- Priority per cycle is CLR > LOAD > tick.
  - CLR: VALUE <= 0, prescaler <= 0, TICK and CARRY not asserted.
  - LOAD: VALUE <= LOAD_VAL, prescaler <= 0, TICK not asserted. With BASE=10, any loaded digit >9 is clamped to 9.
  - Tick: VALUE steps by ±1 in a single cycle (ripple carry/borrow across digits). TICK=1 for that cycle.
- Up count:
  - A digit equal to BASE-1 wraps to 0 and carries into the next digit.
  - All digits at BASE-1 -> all digits 0, CARRY=1.
- Down count:
  - A digit equal to 0 wraps to BASE-1 and borrows from the next digit.
  - All digits 0 -> all digits BASE-1, CARRY=1.
- VALUE, TICK and CARRY are registered; VALUE updates on the same edge that TICK goes high.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and runs independently of EN, CLR and LOAD.
  - On wrap, the digit index advances modulo DIGITS (DIGITS-1 -> 0).
  - With DIGITS=1 the index stays 0.
- SEG and DIG are registered from the same index, so both change on the same edge with no cross-digit glitch.
- Glyphs (a..g, hex value shown as {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
- BLANK_LZ=1: a digit k>0 shows 00 when it and all digits above it are 0. Digit 0 always shows its glyph.
- Polarity inversion is applied last, to both SEG and DIG including the reset values.
- Asserting RESET_N mid-count or mid-scan discards all state immediately.
- After reset release, counting resumes from prescaler 0.

Test Plan (DIGITS=2, TICK_DIV=4, SCAN_DIV=2, BASE=16, polarity params 0 unless stated):
1. Reset, then EN=1, UP=1 for 40 cycles -> TICK every 4th cycle; VALUE sequence 00,01,02..0A; CARRY never set.
2. LOAD_VAL=8'hFE with LOAD pulse, then count up -> VALUE FF then 00 with CARRY=1 on the same cycle as TICK; next tick gives 01 with CARRY=0.
3. BASE=10: load 8'h09 then count up -> VALUE 10. Load 8'h00, UP=0, one tick -> VALUE 99 and CARRY=1. LOAD_VAL=8'hAF -> VALUE 99 (clamped).
4. CLR and LOAD both asserted on a tick cycle with LOAD_VAL=8'h55 -> VALUE 00, TICK=0. EN=0 for 10 cycles -> no TICK, VALUE held.
5. VALUE=8'h3A, scan observed -> DIG alternates 01/10 every 2 cycles; SEG=77 with DIG=01, SEG=4F with DIG=10.
   - With DIG_ACTIVE_LOW=1 and SEG_ACTIVE_LOW=1: DIG=10/01 and SEG=08/30 respectively.
6. BLANK_LZ=1, VALUE=8'h05 -> SEG=00 when DIG=10, SEG=6D when DIG=01. Drop RESET_N mid-count -> all outputs at reset values immediately, with no clock edge.
